// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift sequencer: FSM encoding and default geometry.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 2;
  localparam int DEF_DIVW  = 8;

  // A new word may be taken only between frames or on the closing cycle of one.
  function automatic logic accepts_word(state_e s);
    return (s == IDLE) || (s == DONE);
  endfunction

endpackage

// File: rtl/shift_ctrl_if.sv
// Parallel-side word handshake between the CPU I/O decode and the shift sequencer.
interface shift_ctrl_if import shift_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             busy;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, busy
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, busy
  );

endinterface

// File: rtl/shift_io_reg.sv
// Parallel-load, shift-left register; load wins over shift, zero on reset.
module shift_io_reg import shift_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  input  logic             si,
  output logic [WIDTH-1:0] q,
  output logic             so
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load)       q_d = d;
    else if (shift) q_d = {q_q[WIDTH-2:0], si};
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q  = q_q;
  assign so = q_q[WIDTH-1];

endmodule

// File: rtl/shift_ctrl.sv
// SPI-mode-0 style frame sequencer: FSM, sck half-period divider and bit counter
// driving a tx shifter (mosi) and an rx assembler (miso).
module shift_ctrl import shift_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV,
  parameter int DIVW  = DEF_DIVW
) (
  input  logic          clk,
  input  logic          reset,
  shift_ctrl_if.slave   bus,
  output logic          sck,
  output logic          mosi,
  input  logic          miso,
  output logic          cs_n
);

  localparam int BW = $clog2(WIDTH);

  if (WIDTH < 2)                     begin : g_bad_width $error("WIDTH must be >= 2"); end
  if (DIV < 1)                       begin : g_bad_div   $error("DIV must be >= 1"); end
  if ((DIV - 1) >= (1 << DIVW))      begin : g_bad_divw  $error("DIVW too narrow for DIV-1"); end

  state_e            state_q, state_d;
  logic [DIVW-1:0]   div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              sck_q, sck_d;
  logic              cs_n_q, busy_q, tx_ready_q, rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0]  rx_data_q, rx_data_d;

  logic              tx_load, tx_shift, rx_shift;
  logic [WIDTH-1:0]  tx_ld_data;
  logic [WIDTH-1:0]  rx_q;
  logic              rx_so_unused;
  logic [WIDTH-1:0]  tx_q_unused;
  logic              tx_so;

  logic accept, div_term, last_bit;

  assign accept   = bus.tx_valid && tx_ready_q;
  assign div_term = (div_q == DIVW'(DIV - 1));
  assign last_bit = (bit_q == BW'(WIDTH - 1));

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    sck_d      = sck_q;
    tx_load    = 1'b0;
    tx_ld_data = '0;
    tx_shift   = 1'b0;
    rx_shift   = 1'b0;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          tx_load    = 1'b1;
          tx_ld_data = bus.tx_data;
          bit_d      = '0;
          div_d      = '0;
          sck_d      = 1'b0;
          state_d    = LOW;
        end else if (state_q == DONE) begin
          // Clearing the shifter parks mosi low while idle.
          tx_load = 1'b1;
          state_d = IDLE;
        end
      end
      LOW: begin
        if (div_term) begin
          sck_d    = 1'b1;
          rx_shift = 1'b1;
          div_d    = '0;
          state_d  = HIGH;
        end else begin
          div_d = div_q + DIVW'(1);
        end
      end
      HIGH: begin
        if (div_term) begin
          sck_d = 1'b0;
          div_d = '0;
          if (last_bit) begin
            // Last miso bit was taken on the preceding rise, so rx_q is complete.
            state_d    = DONE;
            rx_valid_d = 1'b1;
            rx_data_d  = rx_q;
          end else begin
            tx_shift = 1'b1;
            bit_d    = bit_q + BW'(1);
            state_d  = LOW;
          end
        end else begin
          div_d = div_q + DIVW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      sck_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sck_q      <= sck_d;
      cs_n_q     <= (state_d == IDLE);
      busy_q     <= (state_d != IDLE);
      tx_ready_q <= accepts_word(state_d);
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  shift_io_reg #(.WIDTH(WIDTH)) u_tx (
    .clk   (clk),
    .reset (reset),
    .load  (tx_load),
    .shift (tx_shift),
    .d     (tx_ld_data),
    .si    (1'b0),
    .q     (tx_q_unused),
    .so    (tx_so)
  );

  shift_io_reg #(.WIDTH(WIDTH)) u_rx (
    .clk   (clk),
    .reset (reset),
    .load  (1'b0),
    .shift (rx_shift),
    .d     ('0),
    .si    (miso),
    .q     (rx_q),
    .so    (rx_so_unused)
  );

  assign sck          = sck_q;
  assign cs_n         = cs_n_q;
  assign mosi         = tx_so;
  assign bus.tx_ready = tx_ready_q;
  assign bus.busy     = busy_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed scoreboard bench: u1 runs DIV=1 in loopback, u2 runs DIV=2 with a scripted miso.
module tb_shift_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  shift_ctrl_if #(.WIDTH(8)) b1 ();
  shift_ctrl_if #(.WIDTH(8)) b2 ();

  logic sck1, mosi1, miso1, cs_n1;
  logic sck2, mosi2, miso2, cs_n2;

  assign miso1 = mosi1;

  shift_ctrl #(.WIDTH(8), .DIV(1), .DIVW(8)) u1 (
    .clk(clk), .reset(reset), .bus(b1), .sck(sck1), .mosi(mosi1), .miso(miso1), .cs_n(cs_n1));
  shift_ctrl #(.WIDTH(8), .DIV(2), .DIVW(8)) u2 (
    .clk(clk), .reset(reset), .bus(b2), .sck(sck2), .mosi(mosi2), .miso(miso2), .cs_n(cs_n2));

  int npass = 0;
  int ntot  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  logic [7:0] exp1[$];
  logic [7:0] exp2[$];

  // Cumulative observation counters; stimulus takes snapshots and checks deltas.
  int cyc = 0, rises1 = 0, rises2 = 0, low1 = 0, low2 = 0, csrise1 = 0;
  int sckhi2 = 0, mosihi2 = 0, rv1 = 0, rv2 = 0, rvc_last1 = 0, rvc_prev1 = 0;
  logic [7:0] cap1 = '0;
  logic sp1 = 1'b0, sp2 = 1'b0, cp1 = 1'b1;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sck1 && !sp1) begin
      rises1 <= rises1 + 1;
      cap1   <= {cap1[6:0], mosi1};
    end
    sp1 <= sck1;
    if (!cs_n1) low1 <= low1 + 1;
    if (cs_n1 && !cp1) csrise1 <= csrise1 + 1;
    cp1 <= cs_n1;
    if (sck2 && !sp2) rises2 <= rises2 + 1;
    sp2 <= sck2;
    if (sck2) sckhi2 <= sckhi2 + 1;
    if (mosi2) mosihi2 <= mosihi2 + 1;
    if (!cs_n2) low2 <= low2 + 1;
    if (b1.rx_valid) begin
      rv1       <= rv1 + 1;
      rvc_prev1 <= rvc_last1;
      rvc_last1 <= cyc;
      if (exp1.size() == 0) check("rx1_unexpected_valid", 32'(1), 32'(0));
      else begin
        check("rx1_data", 32'(b1.rx_data), 32'(exp1[0]));
        void'(exp1.pop_front());
      end
    end
    if (b2.rx_valid) begin
      rv2 <= rv2 + 1;
      if (exp2.size() == 0) check("rx2_unexpected_valid", 32'(1), 32'(0));
      else begin
        check("rx2_data", 32'(b2.rx_data), 32'(exp2[0]));
        void'(exp2.pop_front());
      end
    end
  end

  // miso for u2: next pattern bit, advanced after each observed sck rise.
  logic [7:0] pat2 = '0;
  int base2 = 0;
  always_comb begin
    int k;
    k = rises2 - base2;
    miso2 = (k >= 0 && k < 8) ? pat2[7 - k] : 1'b0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [7:0] d);
    int t = 0;
    while (b1.tx_ready !== 1'b1 && t < 50) begin tick(1); t++; end
    check("tx1_ready_wait", 32'(b1.tx_ready), 32'(1));
    b1.tx_data  = d;
    b1.tx_valid = 1'b1;
    tick(1);
    b1.tx_valid = 1'b0;
  endtask

  task automatic send2(input logic [7:0] d);
    int t = 0;
    while (b2.tx_ready !== 1'b1 && t < 50) begin tick(1); t++; end
    check("tx2_ready_wait", 32'(b2.tx_ready), 32'(1));
    b2.tx_data  = d;
    b2.tx_valid = 1'b1;
    tick(1);
    b2.tx_valid = 1'b0;
  endtask

  initial begin
    int r, l, v, c, h, m, t;
    b1.tx_valid = 1'b0; b1.tx_data = '0;
    b2.tx_valid = 1'b0; b2.tx_data = '0;
    reset = 1'b1;
    tick(3);

    check("rst_cs_n",     32'(cs_n1), 32'(1));
    check("rst_sck",      32'(sck1), 32'(0));
    check("rst_mosi",     32'(mosi1), 32'(0));
    check("rst_busy",     32'(b1.busy), 32'(0));
    check("rst_rx_valid", 32'(b1.rx_valid), 32'(0));
    check("rst_rx_data",  32'(b1.rx_data), 32'(0));
    check("rst_tx_ready", 32'(b1.tx_ready), 32'(0));
    check("rst_cs_n2",    32'(cs_n2), 32'(1));

    reset = 1'b0;
    r = rises1; v = rv1;
    tick(20);
    check("idle_cs_n",     32'(cs_n1), 32'(1));
    check("idle_sck",      32'(sck1), 32'(0));
    check("idle_mosi",     32'(mosi1), 32'(0));
    check("idle_tx_ready", 32'(b1.tx_ready), 32'(1));
    check("idle_busy",     32'(b1.busy), 32'(0));
    check("idle_no_sck",   32'(rises1 - r), 32'(0));
    check("idle_no_rxv",   32'(rv1 - v), 32'(0));

    // Single byte, DIV=1 loopback.
    r = rises1; l = low1; v = rv1;
    exp1.push_back(8'hAE);
    send1(8'hAE);
    check("f1_busy",     32'(b1.busy), 32'(1));
    check("f1_tx_ready", 32'(b1.tx_ready), 32'(0));
    check("f1_cs_n",     32'(cs_n1), 32'(0));
    check("f1_mosi_msb", 32'(mosi1), 32'(1));
    tick(22);
    check("f1_mosi_bits", 32'(cap1), 32'h0000_00AE);
    check("f1_rises",     32'(rises1 - r), 32'(8));
    check("f1_cs_low",    32'(low1 - l), 32'(17));
    check("f1_rxv_count", 32'(rv1 - v), 32'(1));
    check("f1_rx_held",   32'(b1.rx_data), 32'h0000_00AE);
    check("f1_end_cs_n",  32'(cs_n1), 32'(1));
    check("f1_end_mosi",  32'(mosi1), 32'(0));

    // DIV=2 with scripted miso, tx all zeros.
    l = low2; h = sckhi2; m = mosihi2; v = rv2;
    pat2 = 8'h5C; base2 = rises2; r = rises2;
    exp2.push_back(8'h5C);
    send2(8'h00);
    tick(40);
    check("d2_rises",   32'(rises2 - r), 32'(8));
    check("d2_sck_hi",  32'(sckhi2 - h), 32'(16));
    check("d2_cs_low",  32'(low2 - l), 32'(33));
    check("d2_mosi_lo", 32'(mosihi2 - m), 32'(0));
    check("d2_rxv",     32'(rv2 - v), 32'(1));
    check("d2_rx_data", 32'(b2.rx_data), 32'h0000_005C);

    // Back-to-back frames with tx_valid held.
    l = low1; c = csrise1; v = rv1;
    exp1.push_back(8'h81);
    exp1.push_back(8'h3C);
    t = 0;
    while (b1.tx_ready !== 1'b1 && t < 50) begin tick(1); t++; end
    b1.tx_data = 8'h81; b1.tx_valid = 1'b1;
    tick(1);
    b1.tx_data = 8'h3C;
    t = 0;
    while (b1.tx_ready !== 1'b1 && t < 40) begin tick(1); t++; end
    check("b2b_ready_in_done", 32'(b1.tx_ready), 32'(1));
    check("b2b_rxv_in_done",   32'(b1.rx_valid), 32'(1));
    check("b2b_cs_in_done",    32'(cs_n1), 32'(0));
    tick(1);
    b1.tx_valid = 1'b0;
    tick(22);
    check("b2b_cs_low",   32'(low1 - l), 32'(34));
    check("b2b_cs_rises", 32'(csrise1 - c), 32'(1));
    check("b2b_rxv",      32'(rv1 - v), 32'(2));
    check("b2b_spacing",  32'(rvc_last1 - rvc_prev1), 32'(17));

    // tx_valid pulsed mid-frame must be ignored.
    l = low1; v = rv1;
    exp1.push_back(8'h66);
    send1(8'h66);
    tick(1);
    for (int k = 0; k < 8; k++) begin
      b1.tx_data = 8'hFF; b1.tx_valid = 1'b1;
      check("ign_tx_ready", 32'(b1.tx_ready), 32'(0));
      tick(1);
    end
    b1.tx_valid = 1'b0;
    tick(20);
    check("ign_cs_low", 32'(low1 - l), 32'(17));
    check("ign_rxv",    32'(rv1 - v), 32'(1));
    check("ign_rx",     32'(b1.rx_data), 32'h0000_0066);

    // Reset one cycle after the 4th sck rise aborts the frame.
    v = rv1; r = rises1;
    send1(8'hAE);
    t = 0;
    while ((rises1 - r) < 4 && t < 40) begin tick(1); t++; end
    check("abort_4th_rise", 32'(rises1 - r), 32'(4));
    reset = 1'b1;
    tick(1);
    check("abort_cs_n",     32'(cs_n1), 32'(1));
    check("abort_sck",      32'(sck1), 32'(0));
    check("abort_rx_data",  32'(b1.rx_data), 32'(0));
    check("abort_rx_valid", 32'(b1.rx_valid), 32'(0));
    check("abort_busy",     32'(b1.busy), 32'(0));
    reset = 1'b0;
    tick(5);
    check("abort_no_rxv", 32'(rv1 - v), 32'(0));

    exp1.push_back(8'h12);
    send1(8'h12);
    tick(22);
    check("post_abort_mosi", 32'(cap1), 32'h0000_0012);
    check("post_abort_rx",   32'(b1.rx_data), 32'h0000_0012);

    check("sb1_drain", 32'(exp1.size()), 32'(0));
    check("sb2_drain", 32'(exp2.size()), 32'(0));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
